// File: rtl/tiny_npu_pkg.sv
// Shared definitions for the TinyNPU host loader.
//   npu_state_e : controller state codes as reported on npu_state
//   ldr_state_e : host loader sequencer states
package tiny_npu_pkg;

    typedef enum logic [1:0] {
        NPU_LD0 = 2'b00,
        NPU_MAC = 2'b01,
        NPU_LD1 = 2'b10,
        NPU_OUT = 2'b11
    } npu_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDX,
        S_LDW,
        S_GO,
        S_WAIT,
        S_FIN
    } ldr_state_e;

endpackage

// File: rtl/tiny_npu_load_cnt.sv
// Enable/clear up-counter with terminal-count compare.
//   clk, rst : clock, async active-low reset
//   en, clr  : count enable, synchronous clear (clear wins)
//   tc_val   : terminal value compared against the current count
//   cnt, tc  : current count, cnt == tc_val
module tiny_npu_load_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt <= '0;
        else if (clr)   cnt <= '0;
        else if (en)    cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/tiny_npu_host_loader.sv
// Host-side sequencer for one TinyNPU. Takes a layer-count command and a host
// word stream (SIZE x words, then one SIZE*SIZE row-major weight block per
// layer) and replays it as registered x/w load beats, then starts each layer.
//   cmd_*        : command handshake, nlayers field
//   in_*         : host data handshake
//   npu_*_load_* : registered load beats into the NPU (no backpressure)
//   npu_mac_val  : start/continue MAC, npu_out_val : final-layer output request
//   npu_ostream_req, npu_state : controller feedback
//   busy, done   : command in progress, 1-cycle completion pulse
module tiny_npu_host_loader
    import tiny_npu_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int DATA_W  = 8,
    parameter int LAYER_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_val,
    output logic                     cmd_rdy,
    input  logic [LAYER_W-1:0]       cmd_nlayers,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     npu_x_load_val,
    output logic [DATA_W-1:0]        npu_x_load_data,
    output logic                     npu_w_load_val,
    output logic [$clog2(SIZE)-1:0]  npu_w_load_sel,
    output logic [DATA_W-1:0]        npu_w_load_data,
    output logic                     npu_mac_val,
    output logic                     npu_out_val,
    input  logic                     npu_ostream_req,
    input  logic [1:0]               npu_state,
    output logic                     busy,
    output logic                     done
);

    localparam int SEL_W  = $clog2(SIZE);
    localparam int BEAT_W = $clog2(SIZE*SIZE) + 1;

    ldr_state_e          state, state_nxt;
    npu_state_e          ns;
    logic                cmd_beat, in_beat, npu_in_ld, go_armed;
    logic                beat_en, beat_clr, beat_tc;
    logic [BEAT_W-1:0]   beat_idx, beat_tc_val;
    logic [LAYER_W-1:0]  nlayers_q, layer_cnt;
    logic                layer_inc, layer_en, last_layer, seen_req;

    assign ns        = npu_state_e'(npu_state);
    assign cmd_rdy   = (state == S_IDLE) && (ns == NPU_LD0);
    assign in_rdy    = (state == S_LDX) || (state == S_LDW);
    assign cmd_beat  = cmd_val && cmd_rdy;
    assign in_beat   = in_val && in_rdy;
    assign busy      = (state != S_IDLE);
    assign npu_in_ld = (ns == NPU_LD0) || (ns == NPU_LD1);

    // GO spends its first cycle idle (beat_idx==0) so the last weight beat,
    // which is registered, reaches the NPU before the start request.
    assign go_armed    = (state == S_GO) && (beat_idx != '0);
    assign beat_tc_val = (state == S_LDX) ? BEAT_W'(SIZE-1) : BEAT_W'(SIZE*SIZE-1);
    assign beat_clr    = (state_nxt != state);
    assign beat_en     = in_beat || ((state == S_GO) && (beat_idx == '0));
    assign layer_en    = layer_inc && (layer_cnt != '1);

    tiny_npu_load_cnt #(.W(BEAT_W)) u_beat_cnt (
        .clk(clk), .rst(rst), .en(beat_en), .clr(beat_clr),
        .tc_val(beat_tc_val), .cnt(beat_idx), .tc(beat_tc)
    );

    // Terminal count at nlayers-1 flags the final layer.
    tiny_npu_load_cnt #(.W(LAYER_W)) u_layer_cnt (
        .clk(clk), .rst(rst), .en(layer_en), .clr(cmd_beat),
        .tc_val(nlayers_q - 1'b1), .cnt(layer_cnt), .tc(last_layer)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        layer_inc   = 1'b0;
        npu_mac_val = 1'b0;
        npu_out_val = 1'b0;
        case (state)
            S_IDLE: if (cmd_beat && cmd_nlayers != '0) state_nxt = S_LDX;
            S_LDX:  if (in_beat && beat_tc) state_nxt = S_LDW;
            S_LDW:  if (in_beat && beat_tc) state_nxt = S_GO;
            S_GO: if (go_armed) begin
                if (npu_in_ld) begin
                    npu_out_val = last_layer;
                    npu_mac_val = !last_layer;
                end else if (last_layer) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_WAIT;
                    layer_inc = 1'b1;
                end
            end
            // Next layer's x stays inside the NPU; only weights are reloaded.
            S_WAIT: if ((seen_req || npu_ostream_req) && ns == NPU_LD1) state_nxt = S_LDW;
            S_FIN:  if (ns == NPU_OUT) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nlayers_q       <= '0;
            seen_req        <= 1'b0;
            done            <= 1'b0;
            npu_x_load_val  <= 1'b0;
            npu_x_load_data <= '0;
            npu_w_load_val  <= 1'b0;
            npu_w_load_sel  <= '0;
            npu_w_load_data <= '0;
        end else begin
            if (cmd_beat) nlayers_q <= cmd_nlayers;
            seen_req <= (state == S_WAIT) && (seen_req || npu_ostream_req);
            // A zero-layer command completes without touching the NPU.
            done <= (cmd_beat && cmd_nlayers == '0) || (state == S_FIN && ns == NPU_OUT);
            npu_x_load_val <= in_beat && (state == S_LDX);
            npu_w_load_val <= in_beat && (state == S_LDW);
            if (in_beat && state == S_LDX) npu_x_load_data <= in_data;
            if (in_beat && state == S_LDW) begin
                npu_w_load_data <= in_data;
                npu_w_load_sel  <= SEL_W'(beat_idx / BEAT_W'(SIZE));
            end
        end
    end

endmodule

// File: tb/tb_tiny_npu_host_loader.sv
module tb_tiny_npu_host_loader;

    localparam int SIZE = 4, DATA_W = 8, LAYER_W = 4, SEL_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic               cmd_val = 1'b0, cmd_rdy;
    logic [LAYER_W-1:0] cmd_nlayers = '0;
    logic               in_val = 1'b0, in_rdy;
    logic [DATA_W-1:0]  in_data = '0;
    logic               npu_x_load_val, npu_w_load_val, npu_mac_val, npu_out_val;
    logic [DATA_W-1:0]  npu_x_load_data, npu_w_load_data;
    logic [SEL_W-1:0]   npu_w_load_sel;
    logic               npu_ostream_req;
    logic [1:0]         npu_state;
    logic               busy, done;

    tiny_npu_host_loader #(.SIZE(SIZE), .DATA_W(DATA_W), .LAYER_W(LAYER_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_nlayers(cmd_nlayers),
        .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
        .npu_x_load_val(npu_x_load_val), .npu_x_load_data(npu_x_load_data),
        .npu_w_load_val(npu_w_load_val), .npu_w_load_sel(npu_w_load_sel),
        .npu_w_load_data(npu_w_load_data),
        .npu_mac_val(npu_mac_val), .npu_out_val(npu_out_val),
        .npu_ostream_req(npu_ostream_req), .npu_state(npu_state),
        .busy(busy), .done(done)
    );

    // Controller model: LD0 -> MAC on mac_val, MAC lasts 4 cycles then pulses
    // ostream_req entering LD1; in LD1 it ignores ld1_hold request cycles.
    int ld1_hold = 0;
    int mcnt, hcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            npu_state <= 2'b00; npu_ostream_req <= 1'b0; mcnt <= 0; hcnt <= 0;
        end else begin
            npu_ostream_req <= 1'b0;
            case (npu_state)
                2'b00: if (npu_out_val) npu_state <= 2'b11;
                       else if (npu_mac_val) begin npu_state <= 2'b01; mcnt <= 0; end
                2'b01: begin
                    mcnt <= mcnt + 1;
                    if (mcnt == 3) begin npu_state <= 2'b10; npu_ostream_req <= 1'b1; hcnt <= 0; end
                end
                2'b10: if (npu_mac_val || npu_out_val) begin
                    if (hcnt < ld1_hold) hcnt <= hcnt + 1;
                    else if (npu_out_val) npu_state <= 2'b11;
                    else begin npu_state <= 2'b01; mcnt <= 0; end
                end
                default: ;
            endcase
        end
    end

    // Monitor (samples on falling edge)
    int cyc = 0, lat_bad = 0, mac_rise = 0, out_rise = 0, done_cnt = 0, both_cnt = 0;
    int rdy_cnt = 0, mac_drop_bad = 0, mac_hi = 0, cmd_cyc = 0, done_cyc = 0;
    logic prev_mac = 1'b0;
    logic prev_out = 1'b0;
    logic [DATA_W-1:0]       x_obs[$];
    logic [SEL_W+DATA_W-1:0] w_obs[$];
    int acc_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            acc_q.delete();
            prev_mac <= 1'b0;
            prev_out <= 1'b0;
        end else begin
            if (in_val && in_rdy) acc_q.push_back(cyc);
            if (in_rdy) rdy_cnt <= rdy_cnt + 1;
            if (npu_x_load_val || npu_w_load_val) begin
                if (acc_q.size() == 0) lat_bad <= lat_bad + 1;
                else begin
                    if (acc_q[0] != cyc - 1) lat_bad <= lat_bad + 1;
                    void'(acc_q.pop_front());
                end
            end
            if (npu_x_load_val) x_obs.push_back(npu_x_load_data);
            if (npu_w_load_val) w_obs.push_back({npu_w_load_sel, npu_w_load_data});
            if (npu_mac_val && npu_out_val) both_cnt <= both_cnt + 1;
            if (npu_mac_val) mac_hi <= mac_hi + 1;
            if (npu_mac_val && !prev_mac) mac_rise <= mac_rise + 1;
            if (npu_out_val && !prev_out) out_rise <= out_rise + 1;
            if (prev_mac && !npu_mac_val && npu_state != 2'b01) mac_drop_bad <= mac_drop_bad + 1;
            if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
            if (cmd_val && cmd_rdy) cmd_cyc <= cyc;
            prev_mac <= npu_mac_val;
            prev_out <= npu_out_val;
        end
    end

    int total = 0, bad = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cmd_val = 1'b0; in_val = 1'b0;
        @(posedge clk); #2; rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send_cmd(input int n, output bit ok);
        ok = 1'b0;
        cmd_val = 1'b1;
        cmd_nlayers = LAYER_W'(n);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = cmd_rdy;
            @(posedge clk); #1;
        end
        cmd_val = 1'b0;
    endtask

    task automatic send_words(input logic [DATA_W-1:0] w[$], input int pct, output bit ok);
        ok = 1'b1;
        foreach (w[i]) begin
            bit got = 1'b0;
            int guard = 0;
            while (!got && ok) begin
                in_val  = ($urandom_range(0, 99) < pct);
                in_data = in_val ? w[i] : DATA_W'($urandom);
                @(negedge clk); got = in_val && in_rdy;
                @(posedge clk); #1;
                guard++;
                if (guard > 300) ok = 1'b0;
            end
        end
        in_val = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            if (done_cnt > d0) ok = 1'b1;
            else tick();
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        cmd_val = 1'b0; in_val = 1'b0; rst = 1'b0;
        repeat (2) tick();
        total++; if ({npu_x_load_val, npu_w_load_val, npu_mac_val, npu_out_val, busy, done, in_rdy} !== 7'b0) begin
            bad++; $display("FAIL reset_outs got=%b exp=0", {npu_x_load_val, npu_w_load_val, npu_mac_val, npu_out_val, busy, done, in_rdy});
        end
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL reset_cmd_rdy got=%b exp=1", cmd_rdy); end
        rst = 1'b1;
        tick();
        total++; if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset got rdy=%b busy=%b exp 1/0", cmd_rdy, busy);
        end
    endtask

    task automatic test_reset_mid_ldw();
        logic [DATA_W-1:0] wq[$];
        bit ok;
        do_reset();
        ld1_hold = 0;
        for (int i = 0; i < SIZE + 5; i++) wq.push_back(DATA_W'($urandom_range(1, 255)));
        send_cmd(1, ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_cmd got=timeout exp=accepted"); end
        send_words(wq, 100, ok);
        total++; if (!ok || npu_w_load_val !== 1'b1 || npu_w_load_data !== wq[SIZE+4]) begin
            bad++; $display("FAIL midrst_preload got val=%b data=%0h exp 1/%0h", npu_w_load_val, npu_w_load_data, wq[SIZE+4]);
        end
        #2 rst = 1'b0;
        #1;
        total++; if ({npu_x_load_val, npu_w_load_val, npu_mac_val, npu_out_val, npu_w_load_sel,
                      npu_w_load_data, npu_x_load_data} !== '0) begin
            bad++; $display("FAIL midrst_outs got=%0h exp=0", {npu_x_load_val, npu_w_load_val, npu_mac_val,
                            npu_out_val, npu_w_load_sel, npu_w_load_data, npu_x_load_data});
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        tick(); tick();
        rst = 1'b1;
        tick();
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL midrst_cmd_rdy got=%b exp=1", cmd_rdy); end
    endtask

    // Run one command and compare the loads against the host stream:
    // first SIZE words are x, then each SIZE*SIZE block is one layer's weights.
    task automatic run_cmd(input string nm, input int nl, input int pct, input int hold,
                           input int exp_mac_hi, input bit seq_words);
        logic [DATA_W-1:0] wq[$];
        int xs, ws, m0, o0, d0, lb0, b0, md0, mh0, nw;
        bit ok;
        do_reset();
        ld1_hold = hold;
        nw = SIZE + nl * SIZE * SIZE;
        for (int i = 0; i < nw; i++) wq.push_back(seq_words ? DATA_W'(i + 1) : DATA_W'($urandom));
        xs = x_obs.size(); ws = w_obs.size(); m0 = mac_rise; o0 = out_rise; d0 = done_cnt;
        lb0 = lat_bad; b0 = both_cnt; md0 = mac_drop_bad; mh0 = mac_hi;
        send_cmd(nl, ok);
        total++; if (!ok) begin bad++; $display("FAIL %s_cmd got=timeout exp=accepted", nm); end
        send_words(wq, pct, ok);
        total++; if (!ok) begin bad++; $display("FAIL %s_stream got=timeout exp=all accepted", nm); end
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL %s_done_wait got=timeout exp=done", nm); end
        total++; if (x_obs.size() - xs != SIZE) begin
            bad++; $display("FAIL %s_x_count got=%0d exp=%0d", nm, x_obs.size() - xs, SIZE);
        end
        total++; if (w_obs.size() - ws != nl * SIZE * SIZE) begin
            bad++; $display("FAIL %s_w_count got=%0d exp=%0d", nm, w_obs.size() - ws, nl * SIZE * SIZE);
        end
        for (int i = 0; i < SIZE && xs + i < x_obs.size(); i++) begin
            total++; if (x_obs[xs+i] !== wq[i]) begin
                bad++; $display("FAIL %s_x[%0d] got=%0h exp=%0h", nm, i, x_obs[xs+i], wq[i]);
            end
        end
        for (int j = 0; j < nl * SIZE * SIZE && ws + j < w_obs.size(); j++) begin
            logic [SEL_W+DATA_W-1:0] e;
            e = {SEL_W'((j % (SIZE*SIZE)) / SIZE), wq[SIZE+j]};
            total++; if (w_obs[ws+j] !== e) begin
                bad++; $display("FAIL %s_w[%0d] got sel/data=%0h exp=%0h", nm, j, w_obs[ws+j], e);
            end
        end
        total++; if (lat_bad - lb0 != 0) begin bad++; $display("FAIL %s_latency got=%0d late exp=0", nm, lat_bad - lb0); end
        total++; if (mac_rise - m0 != nl - 1) begin bad++; $display("FAIL %s_mac got=%0d exp=%0d", nm, mac_rise - m0, nl - 1); end
        total++; if (mac_hi - mh0 != exp_mac_hi) begin bad++; $display("FAIL %s_mac_hold got=%0d exp=%0d", nm, mac_hi - mh0, exp_mac_hi); end
        total++; if (mac_drop_bad - md0 != 0) begin bad++; $display("FAIL %s_mac_drop got=%0d exp=0", nm, mac_drop_bad - md0); end
        total++; if (out_rise - o0 != 1) begin bad++; $display("FAIL %s_out got=%0d exp=1", nm, out_rise - o0); end
        total++; if (both_cnt - b0 != 0) begin bad++; $display("FAIL %s_both got=%0d exp=0", nm, both_cnt - b0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL %s_done_cnt got=%0d exp=1", nm, done_cnt - d0); end
        total++; if (busy !== 1'b0 || cmd_rdy !== 1'b0 || npu_out_val !== 1'b0) begin
            bad++; $display("FAIL %s_end got busy=%b rdy=%b out=%b exp 0/0/0", nm, busy, cmd_rdy, npu_out_val);
        end
    endtask

    task automatic test_zero_layers();
        int d0, r0, xs, ws;
        bit ok;
        do_reset();
        d0 = done_cnt; r0 = rdy_cnt; xs = x_obs.size(); ws = w_obs.size();
        in_val = 1'b1; in_data = 8'h5a;
        send_cmd(0, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_cmd got=timeout exp=accepted"); end
        repeat (6) tick();
        in_val = 1'b0;
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt - d0); end
        total++; if (done_cyc != cmd_cyc + 1) begin bad++; $display("FAIL zero_done_lat got=%0d exp=%0d", done_cyc - cmd_cyc, 1); end
        total++; if (rdy_cnt - r0 != 0) begin bad++; $display("FAIL zero_in_rdy got=%0d exp=0", rdy_cnt - r0); end
        total++; if (x_obs.size() - xs + w_obs.size() - ws != 0) begin
            bad++; $display("FAIL zero_loads got=%0d exp=0", x_obs.size() - xs + w_obs.size() - ws);
        end
        total++; if (busy !== 1'b0 || cmd_rdy !== 1'b1) begin
            bad++; $display("FAIL zero_end got busy=%b rdy=%b exp 0/1", busy, cmd_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_ldw();
        run_cmd("single", 1, 100, 0, 0, 1'b1);
        run_cmd("multi", 3, 100, 0, 2, 1'b0);
        test_zero_layers();
        run_cmd("stall", 3, 50, 10, 12, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
